// File: rtl/key_input_driver_pkg.sv
// key_input_driver_pkg
//   Shared constants for the key input peripheral: register word offsets
//   on the CPU bridge and the default build parameters.
//   Ports: none (package).
package key_input_driver_pkg;

  // Word offsets selected by bus address bits [3:2].
  localparam logic [1:0] KEY_ADDR_STATE   = 2'd0;
  localparam logic [1:0] KEY_ADDR_PENDING = 2'd1;
  localparam logic [1:0] KEY_ADDR_MASK    = 2'd2;

  localparam int KEY_DEFAULT_N_KEYS          = 8;
  localparam int KEY_DEFAULT_DEBOUNCE_CYCLES = 20000;

endpackage

// File: rtl/key_input_driver_if.sv
// key_input_driver_if
//   Memory-mapped bus seen by the key input peripheral.
//   WE   : write strobe for this device
//   Addr : word select (bus address bits [3:2])
//   Din  : write data
//   Dout : read data, combinational on Addr
//   Modports: master (CPU bridge side), slave (peripheral side).
interface key_input_driver_if;
  logic        WE;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output WE, Addr, Din, input Dout);
  modport slave  (input WE, Addr, Din, output Dout);
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//   Single-key conditioner: 2-flop synchroniser, stability counter and the
//   accepted (debounced) level. A change is accepted only after the
//   synchronised input has differed from `stable` for DEBOUNCE_CYCLES
//   consecutive cycles; any return to the stable level restarts the count.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   key_in : logical key level (1 = pressed), asynchronous
//   stable : debounced level
//   rise   : one-cycle pulse, high in the cycle whose edge accepts 0->1
//   fall   : one-cycle pulse, high in the cycle whose edge accepts 1->0
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // NOTE: the accept decode is combinational so that rise/fall are valid in
  // the same cycle `stable` is about to flip; the parent latches the event
  // on that very edge.
  assign accept = (sync != stable) && (cnt == CNT_LAST);
  assign rise   = accept &&  sync;
  assign fall   = accept && !sync;

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking would collapse the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= key_in;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_input_driver.sv
// key_input_driver
//   Memory-mapped key/switch input peripheral. Debounces N_KEYS pins,
//   latches accepted presses into a sticky write-1-to-clear pending
//   register and raises a level IRQ for pending bits enabled in mask.
//   Build option: define KEY_RELEASE_EVENT_EN to make accepted releases
//   set pending as well.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   bus     : CPU bridge slave (WE, Addr, Din, Dout)
//             Addr 0 = stable (RO), 1 = pending (W1C), 2 = mask (RW),
//             3 = reads 0
//   key_pin : raw board pins, asynchronous
//   IRQ     : registered level interrupt, |(pending & mask)
module key_input_driver
  import key_input_driver_pkg::*;
#(
  parameter int N_KEYS          = KEY_DEFAULT_N_KEYS,
  parameter int DEBOUNCE_CYCLES = KEY_DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  key_input_driver_if.slave   bus,
  input  logic [N_KEYS-1:0]   key_pin,
  output logic                IRQ
);

  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;
  logic [N_KEYS-1:0] event_set;
  logic [N_KEYS-1:0] w1c;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] mask;
  logic              wr_mask;

  // Normalise polarity so everything downstream sees 1 = pressed.
  assign key_level = key_pin ^ {N_KEYS{(ACTIVE_LOW != 0)}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .key_in(key_level[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

`ifdef KEY_RELEASE_EVENT_EN
  assign event_set = rise | fall;
`else
  assign event_set = rise;
  logic unused_fall;
  assign unused_fall = ^fall;
`endif

  // Only the low N_KEYS bits of write data are architecturally stored.
  logic unused_din;
  assign unused_din = ^bus.Din;

  assign w1c     = (bus.WE && bus.Addr == KEY_ADDR_PENDING) ? bus.Din[N_KEYS-1:0] : '0;
  assign wr_mask = bus.WE && bus.Addr == KEY_ADDR_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
      IRQ     <= 1'b0;
    end else begin
      // A new event on the same edge as its W1C wins: the OR comes last.
      pending <= (pending & ~w1c) | event_set;
      if (wr_mask) mask <= bus.Din[N_KEYS-1:0];
      IRQ <= |(pending & mask);
    end
  end

  // NOTE: Dout gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      KEY_ADDR_STATE:   bus.Dout[N_KEYS-1:0] = stable;
      KEY_ADDR_PENDING: bus.Dout[N_KEYS-1:0] = pending;
      KEY_ADDR_MASK:    bus.Dout[N_KEYS-1:0] = mask;
      default:          bus.Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_key_input_driver.sv
// tb_key_input_driver
//   Directed bench for key_input_driver (N_KEYS=8, DEBOUNCE_CYCLES=4,
//   ACTIVE_LOW=1). Expected register/IRQ values are queued as stimulus is
//   driven and compared when drained at the falling clock edge.
module tb_key_input_driver;
  import key_input_driver_pkg::*;

  localparam int NK       = 8;
  localparam int DC       = 4;
  localparam int SEL_IRQ  = 4;
`ifdef KEY_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_pin;
  logic          irq;

  key_input_driver_if bus_if ();

  key_input_driver #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if.slave),
    .key_pin(key_pin),
    .IRQ    (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Pops every queued expectation; each read takes 1 time unit, so callers
  // keep at most four entries queued per half period.
  task automatic drain();
    exp_t       e;
    logic [1:0] saved;
    saved = bus_if.Addr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == SEL_IRQ) begin
        #1;
        check(e.tag, {31'b0, irq}, e.exp);
      end else begin
        bus_if.Addr = e.sel[1:0];
        #1;
        check(e.tag, bus_if.Dout, e.exp);
      end
    end
    bus_if.Addr = saved;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.WE   = 1'b1;
    bus_if.Addr = addr;
    bus_if.Din  = data;
    @(negedge clk);
    bus_if.WE   = 1'b0;
    bus_if.Din  = '0;
  endtask

  initial begin
    reset       = 1'b1;
    key_pin     = 8'hFF;
    bus_if.WE   = 1'b0;
    bus_if.Addr = 2'd0;
    bus_if.Din  = '0;

    // Reset state.
    #5;
    expect_val("rst_state",   0, 32'h0);
    expect_val("rst_pending", 1, 32'h0);
    expect_val("rst_mask",    2, 32'h0);
    expect_val("rst_irq",     SEL_IRQ, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Idle with all keys released.
    for (int k = 0; k < 20; k++) begin
      step(1);
      expect_val("idle_state",   0, 32'h0);
      expect_val("idle_pending", 1, 32'h0);
      expect_val("idle_irq",     SEL_IRQ, 32'h0);
      drain();
    end

    // Press key0: accepted exactly DC+2 edges later.
    key_pin = 8'hFE;
    for (int k = 1; k <= DC + 2; k++) begin
      step(1);
      expect_val("press0_state",   0, (k >= DC + 2) ? 32'h1 : 32'h0);
      expect_val("press0_pending", 1, (k >= DC + 2) ? 32'h1 : 32'h0);
      expect_val("press0_irq",     SEL_IRQ, 32'h0);
      drain();
    end

    // Enable bit0: IRQ follows one cycle after the mask write.
    bus_write(KEY_ADDR_MASK, 32'h1);
    expect_val("mask_rd",       2, 32'h1);
    expect_val("irq_lag",       SEL_IRQ, 32'h0);
    drain();
    step(1);
    expect_val("irq_set",       SEL_IRQ, 32'h1);
    drain();
    bus_write(KEY_ADDR_PENDING, 32'h1);
    expect_val("w1c_pending",   1, 32'h0);
    expect_val("irq_hold",      SEL_IRQ, 32'h1);
    drain();
    step(1);
    expect_val("irq_clear",     SEL_IRQ, 32'h0);
    drain();

    // Two 3-cycle glitches on key3 separated by one released cycle.
    key_pin = 8'hF6;
    step(3);
    key_pin = 8'hFE;
    step(1);
    key_pin = 8'hF6;
    step(3);
    key_pin = 8'hFE;
    for (int k = 0; k < 10; k++) begin
      step(1);
      expect_val("glitch_state",   0, 32'h1);
      expect_val("glitch_pending", 1, 32'h0);
      drain();
    end

    // Press key2 and W1C bit2 on the accept edge: set wins.
    key_pin = 8'hFA;
    step(DC + 1);
    expect_val("pre_accept_state",   0, 32'h1);
    expect_val("pre_accept_pending", 1, 32'h0);
    drain();
    bus_write(KEY_ADDR_PENDING, 32'h4);
    expect_val("setwins_pending", 1, 32'h4);
    expect_val("setwins_state",   0, 32'h5);
    drain();
    bus_write(KEY_ADDR_PENDING, 32'h4);
    expect_val("w1c2_pending", 1, 32'h0);
    expect_val("w1c2_irq",     SEL_IRQ, 32'h0);
    drain();

    // Hold key5 and assert reset asynchronously mid-count.
    key_pin = 8'hDA;
    step(3);
    #3;
    reset = 1'b1;
    expect_val("arst_state",   0, 32'h0);
    expect_val("arst_pending", 1, 32'h0);
    expect_val("arst_mask",    2, 32'h0);
    expect_val("arst_irq",     SEL_IRQ, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= DC + 2; k++) begin
      step(1);
      expect_val("rearm_state",   0, (k >= DC + 2) ? 32'h25 : 32'h0);
      expect_val("rearm_pending", 1, (k >= DC + 2) ? 32'h25 : 32'h0);
      expect_val("rearm_irq",     SEL_IRQ, 32'h0);
      drain();
    end

    // Mask keeps only low N_KEYS bits; IRQ lags the W1C by one cycle.
    bus_write(KEY_ADDR_MASK, 32'hFFFF_FF20);
    expect_val("mask_trunc", 2, 32'h20);
    drain();
    bus_write(KEY_ADDR_PENDING, 32'hFF);
    expect_val("w1c_all",       1, 32'h0);
    expect_val("irq_after_w1c", SEL_IRQ, 32'h1);
    drain();

    // Release key5: pending only with release events enabled.
    key_pin = 8'hFA;
    for (int k = 1; k <= DC + 2; k++) begin
      step(1);
      expect_val("release_state",   0, (k >= DC + 2) ? 32'h05 : 32'h25);
      expect_val("release_pending", 1, (k >= DC + 2 && REL_EN) ? 32'h20 : 32'h0);
      expect_val("release_irq",     SEL_IRQ, 32'h0);
      drain();
    end
    step(1);
    expect_val("release_irq_next", SEL_IRQ, REL_EN ? 32'h1 : 32'h0);
    drain();

    // Writes to the read-only and reserved words are ignored.
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(KEY_ADDR_STATE, 32'hFFFF_FFFF);
    expect_val("addr3_rd",     3, 32'h0);
    expect_val("ro_state",     0, 32'h05);
    expect_val("mask_intact",  2, 32'h20);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
